// File: rtl/pio_gen_pkg.sv
// rtl/pio_gen_pkg.sv - shared register map and edge-type encodings for pio_gen
package pio_gen_pkg;

    localparam logic [2:0] ADDR_DATA    = 3'd0;
    localparam logic [2:0] ADDR_DOUT    = 3'd1;
    localparam logic [2:0] ADDR_IRQMASK = 3'd2;
    localparam logic [2:0] ADDR_EDGECAP = 3'd3;
    localparam logic [2:0] ADDR_OUTSET  = 3'd4;
    localparam logic [2:0] ADDR_OUTCLR  = 3'd5;

    localparam int EDGE_RISE = 0;
    localparam int EDGE_FALL = 1;
    localparam int EDGE_ANY  = 2;

endpackage

// File: rtl/pio_sync_edge.sv
// rtl/pio_sync_edge.sv - input synchroniser, history flop and per-bit edge detect
module pio_sync_edge
    import pio_gen_pkg::*;
#(
    parameter int WIDTH       = 8,
    parameter int SYNC_STAGES = 2,
    parameter int EDGE_TYPE   = EDGE_RISE
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [WIDTH-1:0] in_port,
    output logic [WIDTH-1:0] sync_out,
    output logic [WIDTH-1:0] detect
);

    localparam logic [2:0] FILL = 3'(SYNC_STAGES + 1);

    logic [WIDTH-1:0] r_sync [SYNC_STAGES];
    logic [WIDTH-1:0] r_hist;
    logic [2:0]       r_fill;
    logic             w_armed;
    logic [WIDTH-1:0] w_last;
    logic [WIDTH-1:0] w_edge;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < SYNC_STAGES; i++) r_sync[i] <= '0;
            r_hist <= '0;
            r_fill <= '0;
        end else begin
            r_sync[0] <= in_port;
            for (int i = 1; i < SYNC_STAGES; i++) r_sync[i] <= r_sync[i-1];
            r_hist <= r_sync[SYNC_STAGES-1];
            if (!w_armed) r_fill <= r_fill + 3'd1;
        end
    end

    // Detection stays off until the synchroniser and history have refilled after reset.
    assign w_armed  = (r_fill == FILL);
    assign w_last   = r_sync[SYNC_STAGES-1];
    assign sync_out = w_last;

    always_comb begin
        w_edge = w_last & ~r_hist;
        case (EDGE_TYPE)
            EDGE_FALL: w_edge = ~w_last & r_hist;
            EDGE_ANY:  w_edge = w_last ^ r_hist;
            default:   w_edge = w_last & ~r_hist;
        endcase
    end

    assign detect = w_armed ? w_edge : '0;

endmodule

// File: rtl/pio_gen.sv
// rtl/pio_gen.sv - Avalon parallel I/O port with edge capture and masked interrupt
module pio_gen
    import pio_gen_pkg::*;
#(
    parameter int          WIDTH       = 8,
    parameter logic [31:0] RESET_VALUE = 32'd0,
    parameter int          EDGE_TYPE   = EDGE_RISE,
    parameter int          SYNC_STAGES = 2
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [2:0]       address,
    input  logic             chipselect,
    input  logic             write_n,
    input  logic [WIDTH-1:0] writedata,
    output logic [WIDTH-1:0] readdata,
    input  logic [WIDTH-1:0] in_port,
    output logic [WIDTH-1:0] out_port,
    output logic             irq
);

    logic [WIDTH-1:0] r_data_out;
    logic [WIDTH-1:0] r_irq_mask;
    logic [WIDTH-1:0] r_edge_capture;
    logic [WIDTH-1:0] w_sync;
    logic [WIDTH-1:0] w_detect;
    logic [WIDTH-1:0] w_clr;
    logic             w_wr;

    pio_sync_edge #(
        .WIDTH       (WIDTH),
        .SYNC_STAGES (SYNC_STAGES),
        .EDGE_TYPE   (EDGE_TYPE)
    ) u_sync_edge (
        .clk      (clk),
        .reset_n  (reset_n),
        .in_port  (in_port),
        .sync_out (w_sync),
        .detect   (w_detect)
    );

    assign w_wr  = chipselect & ~write_n;
    assign w_clr = (w_wr && address == ADDR_EDGECAP) ? writedata : '0;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_data_out     <= RESET_VALUE[WIDTH-1:0];
            r_irq_mask     <= '0;
            r_edge_capture <= '0;
        end else begin
            if (w_wr) begin
                case (address)
                    ADDR_DATA:    r_data_out <= writedata;
                    ADDR_OUTSET:  r_data_out <= r_data_out | writedata;
                    ADDR_OUTCLR:  r_data_out <= r_data_out & ~writedata;
                    ADDR_IRQMASK: r_irq_mask <= writedata;
                    default:      ;
                endcase
            end
            // A new detect wins over a same-cycle clear of the same bit.
            r_edge_capture <= (r_edge_capture & ~w_clr) | w_detect;
        end
    end

    always_comb begin
        readdata = '0;
        case (address)
            ADDR_DATA:    readdata = w_sync;
            ADDR_DOUT:    readdata = r_data_out;
            ADDR_IRQMASK: readdata = r_irq_mask;
            ADDR_EDGECAP: readdata = r_edge_capture;
            default:      readdata = '0;
        endcase
    end

    assign out_port = r_data_out;
    assign irq      = |(r_edge_capture & r_irq_mask);

endmodule

// File: doc/pio_gen.md
PIO_GEN -- requirements
Module: pio_gen

Interface
REQ-001 SHALL have parameter WIDTH, default 8, meaning port and register width (1..32).
REQ-002 SHALL have parameter RESET_VALUE, default 0, meaning the out_port value after reset.
REQ-003 SHALL have parameter EDGE_TYPE, default 0, meaning the capture edge: 0 = rising, 1 = falling, 2 = any.
REQ-004 SHALL have parameter SYNC_STAGES, default 2, meaning input synchroniser depth (2..4).
REQ-005 SHALL have port clk, input, 1, the single clock; all state is clocked on its rising edge.
REQ-006 SHALL have port reset_n, input, 1; reset is asynchronous and active-low.
REQ-007 SHALL have port address, input, 3, Avalon register select.
REQ-008 SHALL have port chipselect, input, 1, slave select.
REQ-009 SHALL have port write_n, input, 1, active-low write strobe.
REQ-010 SHALL have port writedata, input, WIDTH, write data.
REQ-011 SHALL have port readdata, output, WIDTH, read data.
REQ-012 SHALL have port in_port, input, WIDTH, asynchronous external inputs.
REQ-013 SHALL have port out_port, output, WIDTH, driven from the data_out register.
REQ-014 SHALL have port irq, output, 1, active-high level interrupt.

Function
REQ-015 SHALL treat a write as chipselect=1 and write_n=0 in one cycle; all register updates take effect on that clock edge.
REQ-016 SHALL implement the address map:
- 0: read = synchronised in_port; write = data_out.
- 1: read = data_out; write ignored.
- 2: irq_mask, read/write.
- 3: edge_capture, read; write-1-to-clear.
- 4: write-only outset, data_out |= writedata.
- 5: write-only outclear, data_out &= ~writedata.
- 6, 7: read 0, writes ignored.
REQ-017 SHALL return readdata combinationally from address with zero wait states, ignoring chipselect; write-only addresses read 0.
REQ-018 SHALL pass each in_port bit through SYNC_STAGES flops, then one history flop; edge detection compares the last synchroniser stage with the history flop.
REQ-019 SHALL set edge_capture[i] in the cycle after a qualifying edge is detected on bit i, per EDGE_TYPE.
REQ-020 SHALL, when a detect and a write-1-to-clear hit the same bit in the same cycle, leave that bit set (set wins).
REQ-021 SHALL keep an edge_capture bit set across repeated edges until software clears it; no counting and no overflow.
REQ-022 SHALL drive irq = OR over (edge_capture & irq_mask), derived from registers only, with no combinational path from bus inputs.
REQ-023 SHALL make reading address 3 side-effect free.
REQ-024 SHALL give in_port-to-capture latency of SYNC_STAGES+1 clocks, and in_port-to-readable-at-address-0 latency of SYNC_STAGES clocks.
REQ-025 SHALL drop writedata bits above WIDTH; readdata bits above WIDTH do not exist.

Reset
REQ-026 SHALL on reset_n=0 asynchronously set data_out=RESET_VALUE, irq_mask=0, edge_capture=0, and clear all synchroniser and history flops, so irq=0.
REQ-027 SHALL NOT capture a spurious edge after reset release while in_port is held constant high, for EDGE_TYPE 0 and 2, until the synchroniser has filled; history flops load the synchronised value for the first SYNC_STAGES+1 cycles with detection suppressed.
REQ-028 SHALL discard any pending edges when reset is asserted mid-operation.

Structure
REQ-029 SHALL place the address constants (ADDR_DATA..ADDR_OUTCLR) and the EDGE_TYPE encodings in shared package pio_gen_pkg.
REQ-030 SHALL use one sub-module, pio_sync_edge, holding the per-bit-vector synchroniser, history flop and edge detect, parameterised by WIDTH, SYNC_STAGES and EDGE_TYPE, with output detect[WIDTH-1:0].

Verification
REQ-031 SHALL cover reset and write (WIDTH=8, RESET_VALUE=8'hA5): release reset -> out_port=A5; write 0x3C to addr 0 -> out_port=3C next cycle; read addr 1 = 3C.
REQ-032 SHALL cover set/clear: data_out=0x0F; write 0xF0 to addr 4 -> 0xFF; write 0x81 to addr 5 -> 0x7E.
REQ-033 SHALL cover rising capture and irq: mask=0x01; in_port[0] 0->1 -> edge_capture=0x01 and irq=1 exactly 3 clocks later (SYNC_STAGES=2); write 0x01 to addr 3 -> irq=0.
REQ-034 SHALL cover set-wins: a detect on bit 2 coincides with a write 0x04 to addr 3 -> edge_capture[2] remains 1.
REQ-035 SHALL cover EDGE_TYPE=2: in_port[1] 0->1->0 with a clear between -> two captures; with mask=0 -> irq stays 0.
REQ-036 SHALL cover mid-operation reset: reset asserted with edge_capture=0xFF and mask=0xFF -> irq=0 immediately, and no capture after release with in_port held at 0xFF.
